// File: rtl/riscv_muldiv_pkg.sv
// Shared RV32/64 M-extension definitions: funct3 operation encoding and funct7 selector.
package riscv_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_t;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic is_div(input muldiv_op_t o);
    return o[2];
  endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative M-extension unit: one shared 2*XLEN shift register does shift-add multiply
// or restoring divide on operand magnitudes, with the sign fixed up in a final cycle.
module riscv_muldiv
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  // Operand conditioning at accept time.
  logic            sa, sb, div_zero, overflow;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sa       = (op inside {MULH, MULHSU, DIV, REM}) && op_a[XLEN-1];
    sb       = (op inside {MULH, DIV, REM}) && op_b[XLEN-1];
    abs_a    = sa ? -op_a : op_a;
    abs_b    = sb ? -op_b : op_b;
    div_zero = is_div(op) && (op_b == '0);
    overflow = (op inside {DIV, REM}) && (op_a == INT_MIN) && (op_b == '1);
  end

  // One iteration of each algorithm; the accumulator is {hi, lo}.
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {2'b00, b_q};
    if (div_diff[XLEN+1])
      div_step = {acc_q[2*XLEN-2:0], 1'b0};
    else
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, fix_result;

  always_comb begin
    prod = negq_q ? -acc_q : acc_q;
    quo  = negq_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = negr_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      MUL:                 fix_result = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_result = prod[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_result = quo;
      default:             fix_result = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    acc_d    = acc_q;
    b_d      = b_q;
    result_d = result_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          b_d     = abs_b;
          negq_d  = sa ^ sb;
          negr_d  = sa;
          count_d = CW'(XLEN-1);
          acc_d   = {{XLEN{1'b0}}, abs_a};
          if (div_zero) begin
            result_d = (op inside {DIV, DIVU}) ? '1 : op_a;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = (op == DIV) ? op_a : '0;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = is_div(op_q) ? div_step : mul_step;
        count_d = count_q - 1'b1;
        if (count_q == '0) state_d = FIX;
      end
      FIX: begin
        result_d = fix_result;
        state_d  = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      count_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      result_q <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      result_q <= result_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign result    = result_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: stimulus pushes expected results, a monitor pops on handshake.
module tb_riscv_muldiv;
  import riscv_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  muldiv_op_t  op;
  logic [31:0] op_a, op_b, result;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;
  logic [31:0] exp_q[$];
  string       nm_q[$];

  riscv_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare whenever the DUT hands over a result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %h, expected no output", result);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string nm = nm_q.pop_front();
        n_txn++;
        $display("txn %0d %s: result=%h expected=%h", n_txn, nm, result, e);
        check(nm, result, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm, input bit expect_out);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout %s: got in_ready 0, expected 1", nm);
    end
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    if (expect_out) begin
      exp_q.push_back(exp);
      nm_q.push_back(nm);
    end
    tick();
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_out(input string nm);
    int t = 0;
    while (!out_valid && t < 100) begin
      tick();
      t++;
    end
    check({nm, "_wait_out"}, {31'b0, out_valid}, 32'd1);
  endtask

  muldiv_op_t  vop[12] = '{MULH, MULHU, MULHSU, DIV, REM, DIVU, REMU, DIV, REM, MULH, REMU, MULHU};
  logic [31:0] va[12]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100,
                           32'd100, 32'd7, 32'd7, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
  logic [31:0] vb[12]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7,
                           32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFFF, 32'd4};
  logic [31:0] ve[12]  = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14,
                           32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'd2};

  muldiv_op_t  sop[6] = '{DIV, REM, DIVU, REMU, DIV, REM};
  logic [31:0] sa[6]  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] sb[6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] se[6]  = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    int errs;
    int t;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = MUL; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    tick();

    // MUL with latency and busy-window checks (cycle 1 = first sample after accept).
    issue(MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7_m3", 1'b1);
    errs = 0;
    for (int c = 1; c <= 33; c++) begin
      if (!busy || out_valid) errs++;
      tick();
    end
    check("mul_busy_window_errs", errs, 32'd0);
    check("mul_out_valid_at_34", {31'b0, out_valid}, 32'd1);
    check("mul_busy_low_in_done", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vop[i], va[i], vb[i], ve[i], $sformatf("vec%0d", i), 1'b1);
      wait_out($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      issue(sop[i], sa[i], sb[i], se[i], $sformatf("special%0d", i), 1'b1);
      check($sformatf("special%0d_latency1", i), {31'b0, out_valid}, 32'd1);
    end

    // Backpressure.
    t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    out_ready = 1'b0;
    issue(MULHU, 32'h12345678, 32'h10, 32'h1, "bp_mulhu", 1'b1);
    wait_out("bp_mulhu");
    errs = 0;
    for (int c = 0; c < 5; c++) begin
      if (!out_valid || in_ready || result !== 32'h1) errs++;
      tick();
    end
    check("bp_stable_errs", errs, 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
    issue(DIVU, 32'd1000, 32'd10, 32'd100, "bp_second", 1'b1);
    wait_out("bp_second");
    tick();

    // Flush mid-CALC.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, "flushed", 1'b0);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_busy", {31'b0, busy}, 32'd0);
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) errs++;
      tick();
    end
    check("flush_no_out_valid", errs, 32'd0);

    // Flush coincident with an accept of a special case discards it.
    op = DIV; op_a = 32'd5; op_b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // Asynchronous reset mid-CALC.
    issue(MUL, 32'd3, 32'd5, 32'd0, "reset_killed", 1'b0);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    issue(DIVU, 32'd9, 32'd3, 32'd3, "divu_9_3", 1'b1);
    wait_out("divu_9_3");

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin tick(); t++; end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
